// File: rtl/spi_ram_arbiter_pkg.sv
// spi_ram_arbiter_pkg: shared widths, RAM command encodings and arbiter FSM states
package spi_ram_arbiter_pkg;
  localparam int MEM_WIDTH = 8;
  localparam int ADDR_SIZE = 8;
  localparam int TIMEOUT_CYC_DEF = 16;
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_ram_cmd_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WAIT,
    S_RESP
  } arb_state_e;
endpackage

// File: rtl/spi_ram_rr_grant.sv
// spi_ram_rr_grant: 2-way round-robin grant; ptr picks the winner only on contention
module spi_ram_rr_grant (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant,
  output logic       next_ptr
);
  assign grant = !en ? 2'b00 : (&req) ? (ptr ? 2'b10 : 2'b01) : req;
  assign next_ptr = (|grant) ? grant[0] : ptr;
endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin front end serialising two requesters onto the SPI RAM command stream
// Optional SPI_RAM_ARB_TIMEOUT_EN adds rsp_err and a read-wait timeout of TIMEOUT_CYC cycles.
module spi_ram_arbiter
  import spi_ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_we,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [2*MEM_WIDTH-1:0] req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [MEM_WIDTH-1:0]   rsp_rdata,
  output logic [MEM_WIDTH+1:0]   ram_din,
  output logic                   ram_rx_valid,
  input  logic [MEM_WIDTH-1:0]   ram_dout,
`ifdef SPI_RAM_ARB_TIMEOUT_EN
  output logic                   rsp_err,
`endif
  input  logic                   ram_tx_valid
);
  arb_state_e             r_state;
  logic                   r_ptr;
  logic                   r_g;
  logic                   r_we;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [MEM_WIDTH-1:0]   r_wdata;
  logic [MEM_WIDTH+1:0]   r_din;
  logic                   r_rx;
  logic [1:0]             r_rsp_valid;
  logic [MEM_WIDTH-1:0]   r_rdata;
  logic [1:0]             w_grant;
  logic                   w_next_ptr;
  logic                   w_en;
  logic                   w_gsel;
  logic                   w_we;
  logic [ADDR_SIZE-1:0]   w_addr;
  logic [MEM_WIDTH-1:0]   w_wdata;
  logic [1:0]             w_onehot;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign rsp_err = r_err;
`endif
  // Gate with rst_n so no accept pulse escapes while reset is held
  assign w_en = rst_n && (r_state == S_IDLE);
  spi_ram_rr_grant u_grant (
    .req      (req_valid),
    .ptr      (r_ptr),
    .en       (w_en),
    .grant    (w_grant),
    .next_ptr (w_next_ptr)
  );
  assign w_gsel   = w_grant[1];
  assign w_we     = req_we[w_gsel];
  assign w_addr   = w_gsel ? req_addr[ADDR_SIZE +: ADDR_SIZE] : req_addr[0 +: ADDR_SIZE];
  assign w_wdata  = w_gsel ? req_wdata[MEM_WIDTH +: MEM_WIDTH] : req_wdata[0 +: MEM_WIDTH];
  assign w_onehot = r_g ? 2'b10 : 2'b01;
  assign req_ready    = w_grant;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rdata;
  assign ram_din      = r_din;
  assign ram_rx_valid = r_rx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_g         <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_din       <= '0;
      r_rx        <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rdata     <= '0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (|w_grant) begin
          r_g     <= w_gsel;
          r_we    <= w_we;
          r_addr  <= w_addr;
          r_wdata <= w_wdata;
          r_ptr   <= w_next_ptr;
          r_din   <= {w_we ? WR_ADDR : RD_ADDR, w_addr};
          r_rx    <= 1'b1;
          r_state <= S_ADDR;
        end
        S_ADDR: begin
          r_din   <= {r_we ? WR_DATA : RD_DATA, r_we ? r_wdata : {MEM_WIDTH{1'b0}}};
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_din       <= '0;
          r_rx        <= 1'b0;
          r_rsp_valid <= r_we ? w_onehot : 2'b00;
          r_state     <= r_we ? S_RESP : S_WAIT;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
          r_cnt       <= '0;
`endif
        end
        S_WAIT: if (ram_tx_valid) begin
          r_rsp_valid <= w_onehot;
          r_rdata     <= ram_dout;
          r_state     <= S_RESP;
        end
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          r_rsp_valid <= w_onehot;
          r_err       <= 1'b1;
          r_state     <= S_RESP;
        end else r_cnt <= r_cnt + 1'b1;
`endif
        S_RESP: begin
          r_rsp_valid <= 2'b00;
          r_rdata     <= '0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
          r_err       <= 1'b0;
`endif
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: scoreboard bench with a behavioural SPI RAM model
module tb_spi_ram_arbiter;
  import spi_ram_arbiter_pkg::*;
  logic        clk = 0, rst_n = 1;
  logic [1:0]  req_valid = 0, req_we = 0;
  logic [15:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata, ram_dout;
  logic [9:0]  ram_din;
  logic        ram_rx_valid, ram_tx_valid;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
  logic        rsp_err;
`endif
  typedef struct {int r; logic [7:0] d; int t; int lat; bit err;} exp_t;
  exp_t       exp_q[$];
  logic [9:0] din_log[$];
  logic [7:0] gold[256];
  logic [7:0] mem[256];
  int         checks = 0, failures = 0, cyc = 0;
  bit         mute = 0;
  logic       s_tx = 0, m_tx = 0;
  logic [7:0] s_do = 0, m_do = 0, m_wa = 0, m_ra = 0;
  assign ram_tx_valid = m_tx | s_tx;
  assign ram_dout = s_tx ? s_do : m_do;

  spi_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_din(ram_din),
    .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout),
`ifdef SPI_RAM_ARB_TIMEOUT_EN
    .rsp_err(rsp_err),
`endif
    .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: answers a read-data command with tx_valid on the next cycle
  always @(posedge clk) begin
    m_tx <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: m_wa <= ram_din[7:0];
        2'b01: mem[m_wa] <= ram_din[7:0];
        2'b10: m_ra <= ram_din[7:0];
        default: if (!mute) begin
          m_tx <= 1'b1;
          m_do <= mem[m_ra];
        end
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rsp_valid != 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: valid=%b rdata=%h required no response", rsp_valid, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (rsp_valid !== (2'b01 << e.r) || rsp_rdata !== e.d || cyc - e.t != e.lat
`ifdef SPI_RAM_ARB_TIMEOUT_EN
              || rsp_err !== e.err
`endif
             ) begin
            failures++;
            $display("FAIL rsp: valid=%b rdata=%h lat=%0d required valid=%b rdata=%h lat=%0d err=%0d",
                     rsp_valid, rsp_rdata, cyc - e.t, 2'b01 << e.r, e.d, e.lat, e.err);
          end
        end
      end
      if (req_ready != 2'b00) begin
        checks++;
        if (req_ready == 2'b11) begin
          failures++;
          $display("FAIL ready_onehot: req_ready=%b required one-hot", req_ready);
        end
      end
      if (ram_rx_valid) din_log.push_back(ram_din);
      else begin
        checks++;
        if (ram_din !== 10'h000) begin
          failures++;
          $display("FAIL din_idle: ram_din=%h required 000", ram_din);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    exp_q.delete();
  endtask

  task automatic issue(input int r, input bit we, input logic [7:0] a, input logic [7:0] d, input bit to = 0);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_we[r] = we;
    req_addr[r*8 +: 8] = a;
    req_wdata[r*8 +: 8] = d;
    #1;
    while (req_ready[r] !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL accept_timeout: req_ready=%b required bit %0d set", req_ready, r);
    end else begin
      e.r = r;
      e.t = cyc;
      e.err = to;
      e.d = (we || to) ? 8'h00 : gold[a];
      e.lat = to ? 3 + TIMEOUT_CYC_DEF : (we ? 3 : 4);
      if (we) gold[a] = d;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    req_addr[r*8 +: 8] = ~a;
    req_wdata[r*8 +: 8] = ~d;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    #3 rst_n = 0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, ram_din, ram_rx_valid} !== 23'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rsp=%b rdata=%h din=%h rx=%b required all 0",
               req_ready, rsp_valid, rsp_rdata, ram_din, ram_rx_valid);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_write();
    din_log.delete();
    issue(0, 1, 8'h3C, 8'hA5);
    drain();
    checks++;
    if (din_log.size() != 2 || din_log[0] !== 10'h03C || din_log[1] !== 10'h1A5) begin
      failures++;
      $display("FAIL write_cmds: n=%0d first=%h second=%h required 03C 1A5", din_log.size(),
               din_log.size() > 0 ? din_log[0] : 10'h0, din_log.size() > 1 ? din_log[1] : 10'h0);
    end
  endtask

  task automatic test_read();
    din_log.delete();
    issue(1, 0, 8'h3C, 8'h00);
    drain();
    checks++;
    if (din_log.size() != 2 || din_log[0] !== 10'h23C || din_log[1] !== 10'h300) begin
      failures++;
      $display("FAIL read_cmds: n=%0d first=%h second=%h required 23C 300", din_log.size(),
               din_log.size() > 0 ? din_log[0] : 10'h0, din_log.size() > 1 ? din_log[1] : 10'h0);
    end
  endtask

  task automatic test_back_to_back();
    int   k = 0, n = 0;
    exp_t e;
    do_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_we = 2'b11;
    req_addr = 16'h2010;
    req_wdata = 16'h2211;
    while (k < 4 && n < 40) begin
      #1;
      if (req_ready != 2'b00) begin
        checks++;
        if (req_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL rr_order: grant %0d req_ready=%b required %b", k, req_ready, (k % 2) ? 2'b10 : 2'b01);
        end
        e.r = req_ready[1] ? 1 : 0;
        e.d = 8'h00;
        e.t = cyc;
        e.lat = 3;
        e.err = 0;
        gold[req_addr[e.r*8 +: 8]] = req_wdata[e.r*8 +: 8];
        exp_q.push_back(e);
        k++;
      end
      n++;
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    checks++;
    if (k != 4) begin
      failures++;
      $display("FAIL b2b_count: grants=%0d required 4", k);
    end
    drain();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    do_reset();
    mute = 1;
    issue(0, 0, 8'h3C, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    req_valid = 2'b11;
    req_we = 2'b11;
    req_addr = 16'h5544;
    req_wdata = 16'h8877;
    rst_n = 0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, ram_din, ram_rx_valid} !== 23'h0) begin
      failures++;
      $display("FAIL abort_outputs: ready=%b rsp=%b rdata=%h din=%h rx=%b required all 0",
               req_ready, rsp_valid, rsp_rdata, ram_din, ram_rx_valid);
    end
    exp_q.delete();
    mute = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL abort_regrant: req_ready=%b required 01", req_ready);
    end else begin
      e.r = 0;
      e.d = 8'h00;
      e.t = cyc;
      e.lat = 3;
      e.err = 0;
      gold[8'h44] = 8'h77;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    drain();
    issue(1, 0, 8'h44, 8'h00);
    drain();
  endtask

  task automatic test_stray();
    @(negedge clk);
    s_tx = 1;
    s_do = 8'hFF;
    @(negedge clk);
    s_tx = 0;
    issue(1, 1, 8'h55, 8'h66);
    drain();
    issue(0, 0, 8'h55, 8'h00);
    drain();
  endtask

`ifdef SPI_RAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    mute = 1;
    issue(0, 0, 8'h3C, 8'h00, 1);
    drain();
    mute = 0;
    issue(1, 0, 8'h3C, 8'h00);
    drain();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      gold[i] = 8'h00;
      mem[i] = 8'h00;
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_abort();
    test_stray();
`ifdef SPI_RAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
Two-requester front end for the single-port SPI RAM. It accepts simple read/write transactions from requester 0 (SPI slave path) and requester 1 (debug/host port), arbitrates round-robin, and serialises each transaction into the RAM's 10-bit command stream ({cmd[1:0], payload[7:0]} on din with rx_valid). Read data returned on the RAM's tx_valid/dout is routed back to the granted requester. Sits between the requesters and the RAM instance; it is the only driver of the RAM's din/rx_valid.

Parameters:
MEM_WIDTH, 8, RAM data width (from shared_pkg)
ADDR_SIZE, 8, RAM address width (from shared_pkg); must equal MEM_WIDTH because the address travels in the payload field
TIMEOUT_CYC, 16, read-wait timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  2  per-requester transaction request
req_we  in  2  per-requester 1=write, 0=read
req_addr  in  2*ADDR_SIZE  per-requester address, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
req_wdata  in  2*MEM_WIDTH  per-requester write data, same packing
req_ready  out  2  one-hot accept pulse
rsp_valid  out  2  one-hot completion pulse
rsp_rdata  out  MEM_WIDTH  read data, valid with rsp_valid; 0 for writes
ram_din  out  MEM_WIDTH+2  command word to RAM
ram_rx_valid  out  1  command strobe to RAM
ram_dout  in  MEM_WIDTH  RAM read data
ram_tx_valid  in  1  RAM read-data strobe

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=0, latched request cleared. ram_din=0, ram_rx_valid=0, rsp_valid=0, rsp_rdata=0, req_ready=0 while rst_n=0. Reset mid-transaction abandons it with no response.
- FSM states: IDLE, ADDR, DATA, WAIT, RESP.
- IDLE: if any req_valid is high, grant g. If both are high, g=rr_ptr; otherwise g is the single requester. req_ready[g]=1 combinationally in that cycle. Latch g, we, addr and wdata. rr_ptr <= ~g. Next state ADDR. With no request, stay in IDLE.
- ADDR (1 cycle): ram_rx_valid=1, ram_din={we?2'b00:2'b10, addr}. Next state DATA.
- DATA (1 cycle): ram_rx_valid=1, ram_din={we?2'b01:2'b11, we?wdata:8'h00}. Next state RESP for a write, WAIT for a read.
- WAIT: ram_rx_valid=0. When ram_tx_valid=1, capture ram_dout and go to RESP. This normally happens in the first WAIT cycle. Otherwise stay in WAIT.
- RESP (1 cycle): rsp_valid[g]=1. rsp_rdata = captured data for a read, 0 for a write. Next state IDLE.
- rsp_valid and rsp_rdata are registered. ram_din and ram_rx_valid are registered; outside ADDR and DATA, ram_rx_valid=0 and ram_din holds 0.
- Latency: write accept-to-rsp = 3 cycles (4 cycles per transaction). Read = 4 cycles minimum (5 per transaction).
- req_valid or req fields changing after acceptance have no effect. A request presented during a busy transaction waits with req_ready=0.
- ram_tx_valid outside WAIT is ignored and nothing is captured.
- Back-to-back requests from both requesters alternate strictly 0,1,0,1. A single active requester is served every transaction.

Optional Feature:
SPI_RAM_ARB_TIMEOUT_EN
- Defined: adds output rsp_err (1 bit, reset 0) and a WAIT-cycle counter. If ram_tx_valid has not arrived after TIMEOUT_CYC cycles in WAIT, go to RESP with rsp_rdata=0 and rsp_err=1 for that single pulse. rsp_err=0 on all normal responses. The counter clears on entry to WAIT.
- Undefined: no counter and no rsp_err port; WAIT holds indefinitely.

Decomposition:
- shared_pkg additions:
  - enum spi_ram_cmd_e: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11
  - enum arb_state_e with the five states
  - TIMEOUT_CYC default constant
- One sub-module: spi_ram_rr_grant, the 2-way round-robin grant logic. Inputs req[1:0], ptr, en. Outputs one-hot grant[1:0] and next_ptr.

Test Plan:
- Write req0 addr=8'h3C data=8'hA5 -> ram_din 10'h03C then 10'h1A5 on consecutive rx_valid cycles; rsp_valid[0] 3 cycles after accept, rsp_rdata=0.
- Read req1 addr=8'h3C after that write, RAM model returns tx_valid one cycle after 11 -> ram_din 10'h23C, 10'h300; rsp_valid[1] with rsp_rdata=8'hA5.
- Both req_valid held high for 4 transactions after reset -> grants 0,1,0,1; req_ready never two-hot.
- rst_n low in WAIT with a read pending -> all outputs 0 immediately; after release no rsp_valid for the aborted read; the next request is granted to requester 0.
- Stray ram_tx_valid=1 with ram_dout=8'hFF in IDLE, then a write -> rsp_rdata stays 0.
- SPI_RAM_ARB_TIMEOUT_EN defined, RAM model never asserts tx_valid -> rsp_valid pulse TIMEOUT_CYC cycles after entering WAIT, rsp_err=1, rsp_rdata=0; the next transaction proceeds normally with rsp_err=0.
